regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the MIPS datapath: two registered read ports, one write port, write-first bypass, optional hard-wired zero register.
- Integrated scoreboard tracks registers with outstanding writes and flags read-after-write hazards to the decode/stall logic.
- Sits between decode (rs/rt/rd fields) and the ALU operand registers.
- Single clock edge (posedge) for both read and write.

---
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with write-first read bypass and a busy-bit scoreboard for RAW hazard detection.
// Latency: A/B/busy_cnt one cycle after rs/rt/issue/we; hazard is combinational from current busy bits.
// Backpressure: none; decode must stall on hazard itself.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int N_REG    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    input  logic                we,
    input  logic [ADDR_W-1:0]   rd,
    input  logic [DATA_W-1:0]   dataIn,
    input  logic                issue,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic                hazard,
    output logic [ADDR_W:0]     busy_cnt
);

    logic [DATA_W-1:0] regs_q [N_REG];
    logic [DATA_W-1:0] regs_d [N_REG];
    logic [N_REG-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_ok, iss_ok, rs_ok, rt_ok;

    // Out-of-range addresses and the hard-wired zero register are inert everywhere.
    function automatic logic legal(input logic [ADDR_W-1:0] x);
        legal = (32'(x) < 32'(N_REG)) && !((ZERO_REG != 0) && (x == '0));
    endfunction

    always_comb begin
        wr_ok      = we && legal(rd);
        iss_ok     = issue && legal(issue_rd);
        rs_ok      = legal(rs);
        rt_ok      = legal(rt);
        regs_d     = regs_q;
        busy_d     = busy_q;
        a_d        = '0;
        b_d        = '0;
        hazard     = 1'b0;
        busy_cnt_d = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (wr_ok && (rd == ADDR_W'(i))) begin
                regs_d[i] = dataIn;
                busy_d[i] = 1'b0;
            end
            // Issue is applied after writeback so a newer pending write keeps the register busy.
            if (iss_ok && (issue_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
            // Reading the next-state array gives the write-first bypass for free.
            if (rs_ok && (rs == ADDR_W'(i))) begin
                a_d    = regs_d[i];
                hazard = hazard | busy_q[i];
            end
            if (rt_ok && (rt == ADDR_W'(i))) begin
                b_d    = regs_d[i];
                hazard = hazard | busy_q[i];
            end
        end
        for (int i = 0; i < N_REG; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 24;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, we, issue;
    logic [AW-1:0] rs, rt, rd, issue_rd;
    logic [DW-1:0] din, a, b;
    logic          hazard;
    logic [AW:0]   busy_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 0;

    logic [DW-1:0] m_reg  [NR];
    bit            m_busy [NR];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .N_REG(NR), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .we(we), .rd(rd), .dataIn(din),
        .issue(issue), .issue_rd(issue_rd), .A(a), .B(b), .hazard(hazard), .busy_cnt(busy_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input int x);
        return (x < NR) && (x != 0);
    endfunction

    function automatic logic [DW-1:0] model_val(input int x);
        if (!legal(x)) return '0;
        if (we && legal(int'(rd)) && (int'(rd) == x)) return din;
        return m_reg[x];
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle();
        rst = 0; we = 0; issue = 0;
        rs = '0; rt = '0; rd = '0; issue_rd = '0; din = '0;
    endtask

    // Inputs are already driven; check hazard, advance one edge, check registered outputs.
    task automatic step();
        logic [DW-1:0] exp_a, exp_b;
        bit exp_haz;
        #1;
        exp_haz = (legal(int'(rs)) && m_busy[rs]) || (legal(int'(rt)) && m_busy[rt]);
        if (started) check("hazard", 64'(hazard), 64'(exp_haz));
        if (rst) begin
            exp_a = '0;
            exp_b = '0;
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 0;
            end
        end else begin
            exp_a = model_val(int'(rs));
            exp_b = model_val(int'(rt));
            if (we && legal(int'(rd))) begin
                m_reg[rd]  = din;
                m_busy[rd] = 0;
            end
            if (issue && legal(int'(issue_rd))) m_busy[issue_rd] = 1;
        end
        @(posedge clk);
        #1;
        started = 1;
        check("A", 64'(a), 64'(exp_a));
        check("B", 64'(b), 64'(exp_b));
        check("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 0;
        end
        idle();
        rst = 1;
        step();

        // reset readback
        idle(); rs = 5'd3; rt = 5'd31;
        step();
        check("rst_A", 64'(a), 64'h0);
        check("rst_B", 64'(b), 64'h0);
        check("rst_haz", 64'(hazard), 64'h0);

        // write then read, one-cycle latency
        idle(); we = 1; rd = 5'd5; din = 32'hDEADBEEF;
        step();
        idle(); rs = 5'd5;
        step();
        check("wr_lat", 64'(a), 64'hDEADBEEF);

        // same-cycle bypass
        idle(); we = 1; rd = 5'd7; din = 32'h12345678; rs = 5'd7; rt = 5'd7;
        step();
        check("bypass_A", 64'(a), 64'h12345678);
        check("bypass_B", 64'(b), 64'h12345678);

        // zero register ignores writes and issues
        idle(); we = 1; rd = 5'd0; din = 32'hFFFFFFFF; issue = 1; issue_rd = 5'd0;
        step();
        idle(); rs = 5'd0;
        #1 check("zero_haz", 64'(hazard), 64'h0);
        step();
        check("zero_A", 64'(a), 64'h0);
        check("zero_cnt", 64'(busy_cnt), 64'h0);

        // scoreboard set, hazard, clear, same-cycle set wins
        idle(); issue = 1; issue_rd = 5'd9;
        step();
        check("iss_cnt", 64'(busy_cnt), 64'h1);
        idle(); rs = 5'd9;
        #1 check("iss_haz", 64'(hazard), 64'h1);
        step();
        idle(); we = 1; rd = 5'd9; din = 32'h99;
        step();
        idle(); rs = 5'd9;
        #1 check("clr_haz", 64'(hazard), 64'h0);
        step();
        idle(); issue = 1; issue_rd = 5'd9; we = 1; rd = 5'd9; din = 32'hAA;
        step();
        check("setwins_cnt", 64'(busy_cnt), 64'h1);
        idle(); we = 1; rd = 5'd9; din = 32'hBB;
        step();

        // reset mid-operation
        for (int r = 2; r <= 6; r += 2) begin
            idle(); issue = 1; issue_rd = AW'(r);
            step();
        end
        check("three_busy", 64'(busy_cnt), 64'h3);
        idle(); rst = 1; we = 1; rd = 5'd2; din = 32'h55;
        step();
        check("midrst_cnt", 64'(busy_cnt), 64'h0);
        idle(); rs = 5'd2;
        #1 check("midrst_haz", 64'(hazard), 64'h0);
        step();
        check("midrst_r2", 64'(a), 64'h0);

        // randomized traffic, addresses biased toward a small window to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst      = ($urandom_range(0, 99) == 0);
            we       = $urandom_range(0, 1) != 0;
            issue    = $urandom_range(0, 1) != 0;
            din      = $urandom;
            if ($urandom_range(0, 1) != 0) begin
                rs = AW'($urandom_range(0, 7)); rt = AW'($urandom_range(0, 7));
                rd = AW'($urandom_range(0, 7)); issue_rd = AW'($urandom_range(0, 7));
            end else begin
                rs = AW'($urandom_range(0, 31)); rt = AW'($urandom_range(0, 31));
                rd = AW'($urandom_range(0, 31)); issue_rd = AW'($urandom_range(0, 31));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
